adsr_envelope: RTL and testbench
================================

Name: adsr_envelope

Overview:
- ADSR envelope controller that drives the 16-bit i_amp input of the amp stage, replacing the fixed 16'hffff amplitude.
- i_gate opens and closes a note; the block steps the amplitude through attack, decay, sustain and release.
- Runs in the 5 MHz synth clock domain.
- Envelope updates happen only on i_tick, a one-cycle sample-rate enable strobe.

Parameters:
- WIDTH, 16, width of the envelope output and of all rate and level inputs. ENV_MAX = all-ones of WIDTH.

Ports:
- i_clk  input  1  synth clock (5 MHz domain)
- i_rst  input  1  synchronous, active-high reset
- i_tick  input  1  envelope update strobe; one cycle wide
- i_gate  input  1  note gate; high = key held
- i_attack_rate  input  WIDTH  per-tick increment in ATTACK; 0 = instant
- i_decay_rate  input  WIDTH  per-tick decrement in DECAY; 0 = instant
- i_sustain_level  input  WIDTH  unsigned sustain target
- i_release_rate  input  WIDTH  per-tick decrement in RELEASE; 0 = instant
- o_env  output  WIDTH  registered unsigned amplitude, fed to amp i_amp
- o_state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- o_active  output  1  high whenever o_state != IDLE
- o_done  output  1  one-cycle pulse when RELEASE reaches 0

Behaviour:
- Reset (synchronous, active-high):
  - o_env=0, o_state=IDLE, o_active=0, o_done=0.
  - gate_d=0, trig_pending=0.
  - Reset overrides every other event, including mid-note and coincident i_tick.
- Gate edge capture (every clock):
  - gate_d <= i_gate.
  - rise = i_gate & ~gate_d.
  - trig = trig_pending | rise.
  - On a non-tick cycle, rise sets trig_pending.
  - On a tick cycle, trig is consumed and trig_pending clears.
  - A rise coincident with i_tick is acted on in that same tick.
- State and o_env change only on i_tick=1 clock edges; outputs are registered, so the new value is visible the cycle after the tick edge.
- Rates and sustain level are sampled on each tick and are not latched. Updates use WIDTH+1-bit intermediate arithmetic with saturation; o_env never wraps.
- Tick transitions, evaluated in priority order:
  1. trig=1, any state -> ATTACK. o_env keeps its current value (legato retrigger, no reset to 0), then the ATTACK step below applies in the same tick.
  2. ATTACK/DECAY/SUSTAIN with i_gate=0 -> RELEASE. o_env unchanged on this tick.
  3. Otherwise, per-state step:
     - IDLE: o_env=0, stays IDLE.
     - ATTACK:
       - sum = o_env + attack_rate.
       - If attack_rate=0 or sum >= ENV_MAX: o_env=ENV_MAX, go to DECAY.
       - Else o_env=sum.
     - DECAY:
       - If decay_rate=0 or o_env - decay_rate <= sustain (signed compare, underflow counts as <=): o_env=sustain, go to SUSTAIN.
       - Else o_env -= decay_rate.
       - If sustain is raised above o_env mid-DECAY, o_env jumps up to sustain.
     - SUSTAIN: o_env = i_sustain_level every tick; it tracks live changes.
     - RELEASE:
       - If release_rate=0 or o_env <= release_rate: o_env=0, go to IDLE, o_done=1 for exactly one cycle.
       - Else o_env -= release_rate.
- Boundary cases:
  - sustain=ENV_MAX: the first DECAY tick lands in SUSTAIN.
  - sustain=0 with gate held: o_env stays 0 in SUSTAIN, o_active stays 1.
  - A trig on the same tick RELEASE would reach 0: ATTACK wins and o_done does not pulse.
  - Gate already low when a pending trig is consumed: ATTACK step runs on that tick, RELEASE entered on the next tick.
- o_done is 0 on every cycle except the single cycle after the release-completing tick edge.

Test Plan:
1. Assert i_rst for 3 cycles mid-SUSTAIN with o_env=0xC000 -> cycle after the first reset edge: o_env=0, o_state=0, o_active=0, o_done=0. Ticks during reset are ignored.
2. Tick every cycle, attack=0x4000, gate rises -> o_env 0x4000, 0x8000, 0xC000, 0xFFFF. o_state=DECAY after the 4th tick.
3. Continue with decay=0x1000, sustain=0xC000 -> o_env 0xEFFF, 0xDFFF, 0xCFFF, 0xC000, state SUSTAIN. Change sustain to 0xA000 -> o_env=0xA000 next tick.
4. Gate low in SUSTAIN at 0xA000, release=0x4000 -> tick1: RELEASE, o_env 0xA000. Then 0x6000, 0x2000, 0x0000 -> IDLE, single-cycle o_done.
5. Tick every 8 cycles, RELEASE at 0x4000, 2-cycle gate pulse between ticks, attack=0x4000 -> next tick ATTACK with o_env=0x8000. Following tick (gate low) -> RELEASE with o_env=0x8000.
6. attack=0, decay=0, sustain=0x3000, gate high -> tick1 o_env=0xFFFF (DECAY), tick2 o_env=0x3000 (SUSTAIN). Gate low, release=0 -> RELEASE, then o_env=0, IDLE, o_done pulse.

Source files
------------

// File: rtl/adsr_envelope.sv
// ADSR envelope controller: steps a WIDTH-bit amplitude through attack, decay,
// sustain and release on each sample-rate tick, driven by a note gate.
module adsr_envelope #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic             i_gate,
    input  logic [WIDTH-1:0] i_attack_rate,
    input  logic [WIDTH-1:0] i_decay_rate,
    input  logic [WIDTH-1:0] i_sustain_level,
    input  logic [WIDTH-1:0] i_release_rate,
    output logic [WIDTH-1:0] o_env,
    output logic [2:0]       o_state,
    output logic             o_active,
    output logic             o_done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [WIDTH:0] ENV_MAX_EXT = {1'b0, {WIDTH{1'b1}}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_env;
    logic [WIDTH-1:0] w_env_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_gate_d;
    logic             r_trig_pending;
    logic             w_trig_pending_nxt;

    logic             w_rise;
    logic             w_trig;
    logic [WIDTH:0]   w_att_sum;
    logic             w_att_full;
    logic [WIDTH:0]   w_dec_diff;
    logic             w_dec_hit;
    logic             w_rel_hit;

    assign w_rise = i_gate & ~r_gate_d;
    assign w_trig = r_trig_pending | w_rise;

    // One extra bit on the step arithmetic: MSB flags overflow (attack) or
    // underflow (decay), both of which clamp to the segment's target.
    assign w_att_sum  = {1'b0, r_env} + {1'b0, i_attack_rate};
    assign w_att_full = (i_attack_rate == '0) || (w_att_sum >= ENV_MAX_EXT);
    assign w_dec_diff = {1'b0, r_env} - {1'b0, i_decay_rate};
    assign w_dec_hit  = (i_decay_rate == '0) || w_dec_diff[WIDTH]
                        || (w_dec_diff[WIDTH-1:0] <= i_sustain_level);
    assign w_rel_hit  = (i_release_rate == '0) || (r_env <= i_release_rate);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_env          <= '0;
            r_done         <= 1'b0;
            r_gate_d       <= 1'b0;
            r_trig_pending <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_env          <= w_env_nxt;
            r_done         <= w_done_nxt;
            r_gate_d       <= i_gate;
            r_trig_pending <= w_trig_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_env_nxt          = r_env;
        w_done_nxt         = 1'b0;
        w_trig_pending_nxt = i_tick ? 1'b0 : w_trig;

        if (i_tick) begin
            // Retrigger keeps the current level (legato) and applies one attack step.
            if (w_trig) begin
                if (w_att_full) begin
                    w_env_nxt   = '1;
                    w_state_nxt = ST_DECAY;
                end else begin
                    w_env_nxt   = w_att_sum[WIDTH-1:0];
                    w_state_nxt = ST_ATTACK;
                end
            end else if (!i_gate && (r_state == ST_ATTACK || r_state == ST_DECAY
                                     || r_state == ST_SUSTAIN)) begin
                w_state_nxt = ST_RELEASE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_env_nxt = '0;
                    end
                    ST_ATTACK: begin
                        if (w_att_full) begin
                            w_env_nxt   = '1;
                            w_state_nxt = ST_DECAY;
                        end else begin
                            w_env_nxt = w_att_sum[WIDTH-1:0];
                        end
                    end
                    ST_DECAY: begin
                        if (w_dec_hit) begin
                            w_env_nxt   = i_sustain_level;
                            w_state_nxt = ST_SUSTAIN;
                        end else begin
                            w_env_nxt = w_dec_diff[WIDTH-1:0];
                        end
                    end
                    ST_SUSTAIN: begin
                        w_env_nxt = i_sustain_level;
                    end
                    ST_RELEASE: begin
                        if (w_rel_hit) begin
                            w_env_nxt   = '0;
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_env_nxt = r_env - i_release_rate;
                        end
                    end
                    default: begin
                        w_env_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_env    = r_env;
    assign o_state  = r_state;
    assign o_active = (r_state != ST_IDLE);
    assign o_done   = r_done;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed envelope scenarios plus a
// randomized run compared cycle-by-cycle against an integer reference model.
module tb_adsr_envelope;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        gate;
    logic [15:0] ar;
    logic [15:0] dr;
    logic [15:0] sus;
    logic [15:0] rr;
    logic [15:0] env;
    logic [2:0]  st;
    logic        act;
    logic        done;

    int total = 0;
    int bad   = 0;

    // Reference model state, plain integers
    int m_env   = 0;
    int m_state = 0;
    int m_done  = 0;
    int m_gd    = 0;
    int m_pend  = 0;

    always #5 clk = ~clk;

    adsr_envelope #(.WIDTH(16)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_tick          (tick),
        .i_gate          (gate),
        .i_attack_rate   (ar),
        .i_decay_rate    (dr),
        .i_sustain_level (sus),
        .i_release_rate  (rr),
        .o_env           (env),
        .o_state         (st),
        .o_active        (act),
        .o_done          (done)
    );

    task automatic attack_step();
        if (ar == 0 || m_env + int'(ar) >= 65535) begin
            m_env   = 65535;
            m_state = 2;
        end else begin
            m_env   = m_env + int'(ar);
            m_state = 1;
        end
    endtask

    // Envelope rules applied to one clock edge with the inputs present at that edge
    task automatic model_step();
        int rise;
        int trig;
        if (rst) begin
            m_env = 0; m_state = 0; m_done = 0; m_gd = 0; m_pend = 0;
        end else begin
            rise   = (gate && m_gd == 0) ? 1 : 0;
            trig   = (m_pend != 0 || rise != 0) ? 1 : 0;
            m_done = 0;
            if (tick) begin
                m_pend = 0;
                if (trig != 0) begin
                    attack_step();
                end else if (!gate && m_state >= 1 && m_state <= 3) begin
                    m_state = 4;
                end else begin
                    case (m_state)
                        0: m_env = 0;
                        1: attack_step();
                        2: begin
                            if (dr == 0 || m_env - int'(dr) <= int'(sus)) begin
                                m_env = int'(sus); m_state = 3;
                            end else begin
                                m_env = m_env - int'(dr);
                            end
                        end
                        3: m_env = int'(sus);
                        default: begin
                            if (rr == 0 || m_env <= int'(rr)) begin
                                m_env = 0; m_state = 0; m_done = 1;
                            end else begin
                                m_env = m_env - int'(rr);
                            end
                        end
                    endcase
                end
            end else if (rise != 0) begin
                m_pend = 1;
            end
            m_gd = gate ? 1 : 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; gate = 1'b0;
        ar = '0; dr = '0; sus = '0; rr = '0;
        step(); step();
        rst = 1'b0;
        total++;
        if ({env, st, act, done} !== 21'h0) begin
            bad++;
            $display("FAIL reset_init got env=%h st=%0d act=%b done=%b need all zero", env, st, act, done);
        end
        ar = 16'h4000; sus = 16'hC000; gate = 1'b1; tick = 1'b1;
        repeat (5) step();
        total++;
        if ({env, st, act, done} !== {16'hC000, 3'd3, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL pre_reset_sustain got env=%h st=%0d need env=c000 st=3", env, st);
        end
        rst = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            total++;
            if ({env, st, act, done} !== 21'h0) begin
                bad++;
                $display("FAIL reset_hold[%0d] got env=%h st=%0d act=%b done=%b need all zero", i, env, st, act, done);
            end
        end
        rst = 1'b0; tick = 1'b0; gate = 1'b0;
        step();
    endtask

    task automatic test_attack();
        logic [15:0] e [4] = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        logic [2:0]  s [4] = '{3'd1, 3'd1, 3'd1, 3'd2};
        ar = 16'h4000; dr = 16'h1000; sus = 16'hC000; gate = 1'b1; tick = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            total++;
            if ({env, st, act, done} !== {e[i], s[i], 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL attack[%0d] got env=%h st=%0d need env=%h st=%0d", i, env, st, e[i], s[i]);
            end
        end
    endtask

    task automatic test_decay();
        logic [15:0] e [4] = '{16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hC000};
        logic [2:0]  s [4] = '{3'd2, 3'd2, 3'd2, 3'd3};
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            total++;
            if ({env, st, act, done} !== {e[i], s[i], 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL decay[%0d] got env=%h st=%0d need env=%h st=%0d", i, env, st, e[i], s[i]);
            end
        end
        sus = 16'hA000;
        step();
        total++;
        if ({env, st} !== {16'hA000, 3'd3}) begin
            bad++;
            $display("FAIL sustain_track got env=%h st=%0d need env=a000 st=3", env, st);
        end
    endtask

    task automatic test_release();
        logic [15:0] e [4] = '{16'hA000, 16'h6000, 16'h2000, 16'h0000};
        logic [2:0]  s [4] = '{3'd4, 3'd4, 3'd4, 3'd0};
        logic        d [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        gate = 1'b0; rr = 16'h4000;
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            total++;
            if ({env, st, act, done} !== {e[i], s[i], (s[i] != 3'd0), d[i]}) begin
                bad++;
                $display("FAIL release[%0d] got env=%h st=%0d act=%b done=%b need env=%h st=%0d done=%b",
                         i, env, st, act, done, e[i], s[i], d[i]);
            end
        end
        step();
        total++;
        if ({env, st, act, done} !== 21'h0) begin
            bad++;
            $display("FAIL done_single got env=%h st=%0d done=%b need idle with done=0", env, st, done);
        end
    endtask

    task automatic test_back_to_back();
        ar = 16'h4000; dr = '0; sus = 16'h4000; gate = 1'b1; tick = 1'b1;
        repeat (5) step();
        gate = 1'b0;
        step();
        total++;
        if ({env, st, act, done} !== {16'h4000, 3'd4, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL enter_release got env=%h st=%0d need env=4000 st=4", env, st);
        end
        rr = 16'h1000;
        for (int unsigned c = 0; c < 8; c++) begin
            tick = (c == 7);
            gate = (c == 2 || c == 3);
            step();
            total++;
            if (c < 7) begin
                if ({env, st, act, done} !== {16'h4000, 3'd4, 1'b1, 1'b0}) begin
                    bad++;
                    $display("FAIL hold_between_ticks[%0d] got env=%h st=%0d need env=4000 st=4", c, env, st);
                end
            end else if ({env, st, act, done} !== {16'h8000, 3'd1, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL pending_retrig got env=%h st=%0d need env=8000 st=1", env, st);
            end
        end
        for (int unsigned c = 0; c < 8; c++) begin
            tick = (c == 7);
            step();
        end
        total++;
        if ({env, st, act, done} !== {16'h8000, 3'd4, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL late_release got env=%h st=%0d need env=8000 st=4", env, st);
        end
        rr = 16'h8000; gate = 1'b1; tick = 1'b1;
        step();
        total++;
        if ({env, st, act, done} !== {16'hC000, 3'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL trig_beats_release got env=%h st=%0d done=%b need env=c000 st=1 done=0", env, st, done);
        end
    endtask

    task automatic test_instant();
        rst = 1'b1; tick = 1'b0; gate = 1'b0;
        step();
        rst = 1'b0;
        ar = '0; dr = '0; sus = 16'h3000; rr = '0; gate = 1'b1; tick = 1'b1;
        step();
        total++;
        if ({env, st} !== {16'hFFFF, 3'd2}) begin
            bad++;
            $display("FAIL instant_attack got env=%h st=%0d need env=ffff st=2", env, st);
        end
        step();
        total++;
        if ({env, st} !== {16'h3000, 3'd3}) begin
            bad++;
            $display("FAIL instant_decay got env=%h st=%0d need env=3000 st=3", env, st);
        end
        sus = '0;
        step();
        total++;
        if ({env, st, act} !== {16'h0000, 3'd3, 1'b1}) begin
            bad++;
            $display("FAIL sustain_zero got env=%h st=%0d act=%b need env=0 st=3 act=1", env, st, act);
        end
        sus = 16'h3000;
        step();
        gate = 1'b0;
        step();
        total++;
        if ({env, st, done} !== {16'h3000, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL instant_rel_enter got env=%h st=%0d need env=3000 st=4", env, st);
        end
        step();
        total++;
        if ({env, st, act, done} !== {16'h0000, 3'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL instant_release got env=%h st=%0d done=%b need env=0 st=0 done=1", env, st, done);
        end
        tick = 1'b0;
        step();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL instant_done_clear got done=%b need 0", done);
        end
        sus = 16'hFFFF; gate = 1'b1; tick = 1'b1;
        step(); step();
        total++;
        if ({env, st} !== {16'hFFFF, 3'd3}) begin
            bad++;
            $display("FAIL sustain_max got env=%h st=%0d need env=ffff st=3", env, st);
        end
    endtask

    function automatic logic [15:0] pick_rate();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2, 3:    return 16'($urandom_range(1, 255));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [20:0] expv;
        rst = 1'b1; tick = 1'b0; gate = 1'b0;
        step();
        rst = 1'b0;
        for (int unsigned n = 0; n < 4000; n++) begin
            if ((n % 40) == 0) begin
                ar = pick_rate(); dr = pick_rate(); rr = pick_rate();
            end
            if ($urandom_range(0, 29) == 0) sus = pick_rate();
            if ($urandom_range(0, 14) == 0) gate = ~gate;
            tick = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 399) == 0);
            step();
            expv = {16'(m_env), 3'(m_state), (m_state != 0), (m_done != 0)};
            total++;
            if ({env, st, act, done} !== expv) begin
                bad++;
                $display("FAIL random[%0d] got env=%h st=%0d act=%b done=%b need env=%h st=%0d act=%b done=%b",
                         n, env, st, act, done, expv[20:5], expv[4:2], expv[1], expv[0]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_attack();
        test_decay();
        test_release();
        test_back_to_back();
        test_instant();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
